// File: rtl/axi4_lite_slave_pkg.sv
// Common types and helpers for AXI4-Lite slave responders.
package axi4_lite_slave_pkg;
   import axi_addr_map_pkg::*;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {W_IDLE, W_RESP} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

   function automatic logic addr_hit(input logic [ADDR_WIDTH-1:0] addr,
                                     input logic [ADDR_WIDTH-1:0] base,
                                     input logic [ADDR_WIDTH-1:0] mask);
      return (addr & mask) == base;
   endfunction
endpackage

// File: rtl/axi_addr_map_pkg.sv
// Shared address-map constants for the interconnect and its slave ports.
package axi_addr_map_pkg;
   localparam int ADDR_WIDTH = 32;
   localparam int DATA_WIDTH = 32;
   localparam int SLAVE_NUM  = 1;
endpackage

// File: rtl/axi4_lite_ram_slave_if.sv
// AXI4-Lite slave-port bundle. A transfer happens on every rising clk edge where
// valid and ready are both 1; once raised, valid and its payload hold until that edge.
interface axi4_lite_ram_slave_if #(
   parameter int ADDR_WIDTH = axi_addr_map_pkg::ADDR_WIDTH,
   parameter int DATA_WIDTH = axi_addr_map_pkg::DATA_WIDTH
);
   logic [ADDR_WIDTH-1:0]   s_awaddr;
   logic                    s_awvalid;
   logic                    s_awready;
   logic [DATA_WIDTH-1:0]   s_wdata;
   logic [DATA_WIDTH/8-1:0] s_wstrb;
   logic                    s_wvalid;
   logic                    s_wready;
   logic [1:0]              s_bresp;
   logic                    s_bvalid;
   logic                    s_bready;
   logic [ADDR_WIDTH-1:0]   s_araddr;
   logic                    s_arvalid;
   logic                    s_arready;
   logic [DATA_WIDTH-1:0]   s_rdata;
   logic [1:0]              s_rresp;
   logic                    s_rvalid;
   logic                    s_rready;

   modport slave (
      input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
             s_araddr, s_arvalid, s_rready,
      output s_awready, s_wready, s_bresp, s_bvalid, s_arready, s_rdata, s_rresp, s_rvalid
   );

   modport master (
      output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
             s_araddr, s_arvalid, s_rready,
      input  s_awready, s_wready, s_bresp, s_bvalid, s_arready, s_rdata, s_rresp, s_rvalid
   );
endinterface

// File: rtl/axi4_lite_ram_core.sv
// Word-organised RAM: byte-enable synchronous write port, registered read port, no array reset.
module axi4_lite_ram_core #(
   parameter int  MEM_DEPTH = 64,
   localparam int IDX_W     = $clog2(MEM_DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [IDX_W-1:0] w_idx,
   input  logic [31:0]      w_data,
   input  logic [3:0]       w_strb,
   input  logic             re,
   input  logic [IDX_W-1:0] r_idx,
   output logic [31:0]      r_data
);
   logic [31:0] mem [MEM_DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < 4; b++) begin
            if (w_strb[b]) mem[w_idx][b*8 +: 8] <= w_data[b*8 +: 8];
         end
      end
   end

   // Read samples the array before a same-edge write lands, so collisions return old data.
   always_ff @(posedge clk) begin
      if (rst)     r_data <= '0;
      else if (re) r_data <= mem[r_idx];
   end
endmodule

// File: rtl/axi4_lite_ram_slave.sv
// AXI4-Lite RAM responder with independent write/read FSMs.
// Define AXI4_LITE_RAM_REG_RD_EN to add an output register stage on the read path.
module axi4_lite_ram_slave
   import axi4_lite_slave_pkg::*;
#(
   parameter int ADDR_WIDTH = axi_addr_map_pkg::ADDR_WIDTH,
   parameter int DATA_WIDTH = axi_addr_map_pkg::DATA_WIDTH,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'h0000_0000,
   parameter logic [ADDR_WIDTH-1:0] ADDR_MASK = 32'hFFFF_FF00,
   parameter int MEM_DEPTH = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   axi4_lite_ram_slave_if.slave  s,
   output w_state_t              w_state_dbg,
   output r_state_t              r_state_dbg
);
   localparam int IDX_W  = $clog2(MEM_DEPTH);
   localparam int STRB_W = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_DEPTH * 4);

   // A hit must fall in the window and inside the populated part of it.
   function automatic logic decode(input logic [ADDR_WIDTH-1:0] a);
      return addr_hit(a, BASE_ADDR, ADDR_MASK) && ((a & ~ADDR_MASK) < MEM_BYTES);
   endfunction

   w_state_t              w_state, w_state_nx;
   logic                  aw_held, w_held;
   logic [ADDR_WIDTH-1:0] aw_addr_q;
   logic [DATA_WIDTH-1:0] w_data_q;
   logic [STRB_W-1:0]     w_strb_q;
   logic [1:0]            bresp_q;
   logic                  aw_fire, w_fire, commit, wr_hit;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [STRB_W-1:0]     wr_strb;

   r_state_t              r_state, r_state_nx;
   logic                  ar_fire, rd_hit, rd_hit_q;
   logic [1:0]            rresp_q;
   logic [DATA_WIDTH-1:0] core_rdata;

   always_comb begin
      w_state_nx  = w_state;
      s.s_awready = 1'b0;
      s.s_wready  = 1'b0;
      s.s_bvalid  = 1'b0;
      aw_fire     = 1'b0;
      w_fire      = 1'b0;
      commit      = 1'b0;
      wr_addr     = aw_held ? aw_addr_q : s.s_awaddr;
      wr_data     = w_held  ? w_data_q  : s.s_wdata;
      wr_strb     = w_held  ? w_strb_q  : s.s_wstrb;
      wr_hit      = decode(wr_addr);
      case (w_state)
         W_IDLE: begin
            s.s_awready = !aw_held;
            s.s_wready  = !w_held;
            aw_fire     = s.s_awvalid && !aw_held;
            w_fire      = s.s_wvalid && !w_held;
            commit      = (aw_held || aw_fire) && (w_held || w_fire);
            if (commit) w_state_nx = W_RESP;
         end
         W_RESP: begin
            s.s_bvalid = 1'b1;
            if (s.s_bready) w_state_nx = W_IDLE;
         end
         default: w_state_nx = W_IDLE;
      endcase
      if (rst) begin
         s.s_awready = 1'b0;
         s.s_wready  = 1'b0;
         s.s_bvalid  = 1'b0;
         aw_fire     = 1'b0;
         w_fire      = 1'b0;
         commit      = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         w_state   <= W_IDLE;
         aw_held   <= 1'b0;
         w_held    <= 1'b0;
         aw_addr_q <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         bresp_q   <= RESP_OKAY;
      end else begin
         w_state <= w_state_nx;
         if (commit) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            bresp_q <= wr_hit ? RESP_OKAY : RESP_SLVERR;
         end else begin
            if (aw_fire) begin
               aw_held   <= 1'b1;
               aw_addr_q <= s.s_awaddr;
            end
            if (w_fire) begin
               w_held   <= 1'b1;
               w_data_q <= s.s_wdata;
               w_strb_q <= s.s_wstrb;
            end
         end
      end
   end

   assign s.s_bresp   = bresp_q;
   assign w_state_dbg = w_state;

   always_comb begin
      r_state_nx  = r_state;
      s.s_arready = 1'b0;
      s.s_rvalid  = 1'b0;
      ar_fire     = 1'b0;
      rd_hit      = decode(s.s_araddr);
      case (r_state)
         R_IDLE: begin
            s.s_arready = 1'b1;
            ar_fire     = s.s_arvalid;
`ifdef AXI4_LITE_RAM_REG_RD_EN
            if (ar_fire) r_state_nx = R_WAIT;
`else
            if (ar_fire) r_state_nx = R_DATA;
`endif
         end
`ifdef AXI4_LITE_RAM_REG_RD_EN
         R_WAIT: r_state_nx = R_DATA;
`endif
         R_DATA: begin
            s.s_rvalid = 1'b1;
            if (s.s_rready) r_state_nx = R_IDLE;
         end
         default: r_state_nx = R_IDLE;
      endcase
      if (rst) begin
         s.s_arready = 1'b0;
         s.s_rvalid  = 1'b0;
         ar_fire     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= R_IDLE;
         rd_hit_q <= 1'b0;
         rresp_q  <= RESP_OKAY;
      end else begin
         r_state <= r_state_nx;
         if (ar_fire) begin
            rd_hit_q <= rd_hit;
            rresp_q  <= rd_hit ? RESP_OKAY : RESP_SLVERR;
         end
      end
   end

`ifdef AXI4_LITE_RAM_REG_RD_EN
   logic [DATA_WIDTH-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (rst)                     rdata_q <= '0;
      else if (r_state == R_WAIT)  rdata_q <= rd_hit_q ? core_rdata : '0;
   end

   assign s.s_rdata = rdata_q;
`else
   assign s.s_rdata = rd_hit_q ? core_rdata : '0;
`endif

   assign s.s_rresp   = rresp_q;
   assign r_state_dbg = r_state;

   axi4_lite_ram_core #(.MEM_DEPTH(MEM_DEPTH)) u_core (
      .clk    (clk),
      .rst    (rst),
      .we     (commit && wr_hit),
      .w_idx  (wr_addr[IDX_W+1:2]),
      .w_data (wr_data),
      .w_strb (wr_strb),
      .re     (ar_fire && rd_hit),
      .r_idx  (s.s_araddr[IDX_W+1:2]),
      .r_data (core_rdata)
   );
endmodule

// File: tb/tb_axi4_lite_ram_slave.sv
// Randomised and directed bench for axi4_lite_ram_slave against a word-array reference model.
module tb_axi4_lite_ram_slave;
   import axi4_lite_slave_pkg::*;

   localparam logic [31:0] WIN_BASE  = 32'h0000_0000;
   localparam logic [31:0] WIN_BYTES = 32'h0000_0100;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   axi4_lite_ram_slave_if bus();
   w_state_t w_state_dbg;
   r_state_t r_state_dbg;

   axi4_lite_ram_slave dut (
      .clk         (clk),
      .rst         (rst),
      .s           (bus),
      .w_state_dbg (w_state_dbg),
      .r_state_dbg (r_state_dbg)
   );

   logic [31:0] model [64];
   logic [31:0] exp_q [$];
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit in_window(input logic [31:0] a);
      return (a >= WIN_BASE) && (a < WIN_BASE + WIN_BYTES);
   endfunction

   function automatic int word_of(input logic [31:0] a);
      return int'((a - WIN_BASE) >> 2);
   endfunction

   function automatic logic [31:0] rand_addr();
      if ($urandom_range(0, 3) == 0) return 32'h100 + 32'($urandom_range(0, 32'h7FF));
      return 32'($urandom_range(0, 255));
   endfunction

   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_delay, input int w_delay, input int b_hold,
                            output logic [1:0] resp);
      int cyc = 0;
      bit aw_done = 0, w_done = 0, aw_f, w_f;
      logic [1:0] exp_resp;
      @(negedge clk);
      bus.s_awaddr  = addr;
      bus.s_wdata   = data;
      bus.s_wstrb   = strb;
      bus.s_awvalid = (aw_delay == 0);
      bus.s_wvalid  = (w_delay == 0);
      while (!(aw_done && w_done) && cyc < 50) begin
         aw_f = bus.s_awvalid && bus.s_awready;
         w_f  = bus.s_wvalid && bus.s_wready;
         @(posedge clk);
         if ((aw_done || aw_f) && (w_done || w_f) && in_window(addr)) begin
            for (int b = 0; b < 4; b++)
               if (strb[b]) model[word_of(addr)][b*8 +: 8] = data[b*8 +: 8];
         end
         @(negedge clk);
         cyc++;
         if (aw_f) begin aw_done = 1; bus.s_awvalid = 1'b0; end
         if (w_f)  begin w_done  = 1; bus.s_wvalid  = 1'b0; end
         if (!aw_done && cyc >= aw_delay) bus.s_awvalid = 1'b1;
         if (!w_done && cyc >= w_delay)   bus.s_wvalid  = 1'b1;
      end
      if (!(aw_done && w_done)) begin
         check("write_timeout", 32'(cyc), 32'd0);
         bus.s_awvalid = 1'b0;
         bus.s_wvalid  = 1'b0;
         resp = 2'bxx;
         return;
      end
      exp_resp = in_window(addr) ? 2'b00 : 2'b10;
      check("bvalid_latency", 32'(bus.s_bvalid), 32'd1);
      check("bresp", 32'(bus.s_bresp), 32'(exp_resp));
      for (int i = 0; i < b_hold; i++) begin
         @(negedge clk);
         check("bvalid_hold", 32'(bus.s_bvalid), 32'd1);
         check("bresp_hold", 32'(bus.s_bresp), 32'(exp_resp));
         check("aw_w_ready_in_resp", 32'({bus.s_awready, bus.s_wready}), 32'd0);
      end
      resp = bus.s_bresp;
      bus.s_bready = 1'b1;
      @(negedge clk);
      bus.s_bready = 1'b0;
      check("bvalid_drop", 32'(bus.s_bvalid), 32'd0);
      check("aw_w_ready_back", 32'({bus.s_awready, bus.s_wready}), 32'd3);
   endtask

   task automatic axi_read(input logic [31:0] addr, input int ar_delay, input int r_hold,
                           output logic [31:0] rd);
      int cyc = 0;
      bit done = 0, f;
      logic [31:0] exp_d;
      logic [1:0] exp_r = 2'b00;
      @(negedge clk);
      bus.s_araddr  = addr;
      bus.s_arvalid = (ar_delay == 0);
      while (!done && cyc < 50) begin
         f = bus.s_arvalid && bus.s_arready;
         if (f) begin
            exp_q.push_back(in_window(addr) ? model[word_of(addr)] : 32'h0);
            exp_r = in_window(addr) ? 2'b00 : 2'b10;
         end
         @(negedge clk);
         cyc++;
         if (f) begin done = 1; bus.s_arvalid = 1'b0; end
         else if (cyc >= ar_delay) bus.s_arvalid = 1'b1;
      end
      if (!done) begin
         check("read_timeout", 32'(cyc), 32'd0);
         bus.s_arvalid = 1'b0;
         rd = 'x;
         return;
      end
`ifdef AXI4_LITE_RAM_REG_RD_EN
      check("rvalid_wait", 32'(bus.s_rvalid), 32'd0);
      @(negedge clk);
`endif
      exp_d = exp_q.pop_front();
      check("rvalid_latency", 32'(bus.s_rvalid), 32'd1);
      check("rdata", bus.s_rdata, exp_d);
      check("rresp", 32'(bus.s_rresp), 32'(exp_r));
      for (int i = 0; i < r_hold; i++) begin
         @(negedge clk);
         check("rvalid_hold", 32'(bus.s_rvalid), 32'd1);
         check("rdata_hold", bus.s_rdata, exp_d);
         check("arready_in_data", 32'(bus.s_arready), 32'd0);
      end
      rd = bus.s_rdata;
      bus.s_rready = 1'b1;
      @(negedge clk);
      bus.s_rready = 1'b0;
      check("rvalid_drop", 32'(bus.s_rvalid), 32'd0);
      check("arready_back", 32'(bus.s_arready), 32'd1);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]  resp, resp2;
      logic [31:0] rd, rd2, a1, a2, d;
      logic [3:0]  st;
      int ad, wd, bh, rh;
      bus.s_awaddr = '0; bus.s_awvalid = 0; bus.s_wdata = '0; bus.s_wstrb = '0;
      bus.s_wvalid = 0; bus.s_bready = 0; bus.s_araddr = '0; bus.s_arvalid = 0; bus.s_rready = 0;
      for (int i = 0; i < 64; i++) model[i] = 32'h0;

      repeat (2) @(negedge clk);
      check("rst_ready", 32'({bus.s_awready, bus.s_wready, bus.s_arready}), 32'd0);
      check("rst_valid", 32'({bus.s_bvalid, bus.s_rvalid}), 32'd0);
      check("rst_resp", 32'({bus.s_bresp, bus.s_rresp}), 32'd0);
      check("rst_rdata", bus.s_rdata, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_ready", 32'({bus.s_awready, bus.s_wready, bus.s_arready}), 32'd7);
      check("idle_states", 32'({w_state_dbg, r_state_dbg}), 32'({W_IDLE, R_IDLE}));

      // Clear the RAM through the bus so every word has a known value.
      for (int i = 0; i < 64; i++) axi_write(32'(i * 4), 32'h0, 4'hF, 0, 0, 0, resp);

      axi_write(32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, resp);
      check("tp1_bresp", 32'(resp), 32'd0);
      axi_read(32'h10, 0, 0, rd);
      check("tp1_rdata", rd, 32'hDEAD_BEEF);

      axi_write(32'h10, 32'h1122_3344, 4'b0101, 3, 0, 0, resp);
      axi_read(32'h10, 0, 0, rd);
      check("tp2_rdata", rd, 32'hDE22_BE44);

      axi_write(32'h200, 32'h5555_AAAA, 4'hF, 0, 0, 0, resp);
      check("tp3_bresp", 32'(resp), 32'd2);
      axi_read(32'h0, 0, 0, rd);
      check("tp3_word0_unchanged", rd, 32'h0);
      axi_read(32'h200, 0, 0, rd);
      check("tp3_rdata", rd, 32'h0);

      axi_write(32'h40, 32'h0BAD_CAFE, 4'hF, 0, 0, 5, resp);
      axi_write(32'h44, 32'h1234_5678, 4'hF, 0, 0, 0, resp);

      fork
         axi_write(32'h20, 32'h5, 4'hF, 0, 0, 0, resp);
         axi_read(32'h20, 0, 0, rd);
      join
      check("tp5_collision", rd, 32'h0);
      axi_read(32'h20, 0, 0, rd);
      check("tp5_after", rd, 32'h5);

      axi_write(32'h13, 32'hA5A5_0001, 4'hF, 0, 2, 1, resp);
      axi_read(32'h12, 1, 2, rd);
      check("unaligned", rd, 32'hA5A5_0001);

      for (int i = 0; i < 70; i++) begin
         a1 = rand_addr(); a2 = rand_addr(); d = $urandom; st = 4'($urandom_range(0, 15));
         ad = $urandom_range(0, 3); wd = $urandom_range(0, 3);
         bh = $urandom_range(0, 2); rh = $urandom_range(0, 2);
         case ($urandom_range(0, 2))
            0: axi_write(a1, d, st, ad, wd, bh, resp);
            1: axi_read(a2, ad, rh, rd);
            default: fork
               axi_write(a1, d, st, ad, wd, bh, resp2);
               axi_read(a2, wd, rh, rd2);
            join
         endcase
      end

      // Reset while the write channel is in W_RESP and the read channel in R_DATA.
      @(negedge clk);
      bus.s_awaddr = 32'h30; bus.s_wdata = 32'hCAFE_F00D; bus.s_wstrb = 4'hF;
      bus.s_awvalid = 1; bus.s_wvalid = 1; bus.s_araddr = 32'h10; bus.s_arvalid = 1;
      @(posedge clk);
      model[12] = 32'hCAFE_F00D;
      @(negedge clk);
      bus.s_awvalid = 0; bus.s_wvalid = 0; bus.s_arvalid = 0;
      @(negedge clk);
      check("pre_rst_valids", 32'({bus.s_bvalid, bus.s_rvalid}), 32'd3);
      rst = 1'b1;
      @(negedge clk);
      check("in_rst_valids", 32'({bus.s_bvalid, bus.s_rvalid}), 32'd0);
      check("in_rst_ready", 32'({bus.s_awready, bus.s_wready, bus.s_arready}), 32'd0);
      check("in_rst_rdata", bus.s_rdata, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_ready", 32'({bus.s_awready, bus.s_wready, bus.s_arready}), 32'd7);
      check("post_rst_valids", 32'({bus.s_bvalid, bus.s_rvalid}), 32'd0);

      // A W captured before reset must not pair with an AW after it.
      bus.s_awaddr = 32'h34; bus.s_wdata = 32'hBADB_AD00; bus.s_wstrb = 4'hF; bus.s_wvalid = 1;
      @(negedge clk);
      bus.s_wvalid = 0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("w_discard_wready", 32'(bus.s_wready), 32'd1);
      bus.s_awvalid = 1;
      @(negedge clk);
      bus.s_awvalid = 0;
      repeat (2) @(negedge clk);
      check("w_discard_no_bvalid", 32'(bus.s_bvalid), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      axi_read(32'h30, 0, 0, rd);
      check("rst_kept_0x30", rd, 32'hCAFE_F00D);
      axi_read(32'h34, 0, 0, rd);
      axi_read(32'h20, 0, 0, rd);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
